// File: rtl/scfifo_pkg.sv
// Shared constants and helpers for the parametrised single-clock count FIFO.
package scfifo_pkg;

  localparam int unsigned FWFT_MODE_REG  = 0;
  localparam int unsigned FWFT_MODE_FALL = 1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Occupancy needs one extra bit so that DEPTH itself is representable.
  function automatic int unsigned count_width(input int unsigned depth_log2);
    return depth_log2 + 1;
  endfunction

endpackage

// File: rtl/scfifo_param_withcount_if.sv
// Push/pop/status bundle of the count FIFO; master is the user side, slave the FIFO.
interface scfifo_param_withcount_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH_LOG2 = 6
);
  logic [DATA_WIDTH-1:0] iPushData;
  logic                  iPushEnable;
  logic                  oIsFull;
  logic                  oAlmostFull;
  logic [DATA_WIDTH-1:0] oPopData;
  logic                  iPopEnable;
  logic                  oIsEmpty;
  logic                  oAlmostEmpty;
  logic [DEPTH_LOG2:0]   oDataCount;
  logic                  oOverflow;
  logic                  oUnderflow;
  logic                  iClearErr;

  modport master (
    output iPushData, iPushEnable, iPopEnable, iClearErr,
    input  oIsFull, oAlmostFull, oPopData, oIsEmpty, oAlmostEmpty,
    input  oDataCount, oOverflow, oUnderflow
  );

  modport slave (
    input  iPushData, iPushEnable, iPopEnable, iClearErr,
    output oIsFull, oAlmostFull, oPopData, oIsEmpty, oAlmostEmpty,
    output oDataCount, oOverflow, oUnderflow
  );
endinterface

// File: rtl/scfifo_regarray.sv
// Unreset storage array: synchronous write port, combinational read port.
module scfifo_regarray
  import scfifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 64
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [clog2(DEPTH)-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [clog2(DEPTH)-1:0]      raddr,
  output logic [DATA_WIDTH-1:0]        rdata_c
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_c = mem_q[raddr];
endmodule

// File: rtl/scfifo_param_withcount.sv
// Single-clock FIFO with full-range count, threshold flags, sticky errors and
// selectable fall-through or registered read data.
module scfifo_param_withcount
  import scfifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned DEPTH_LOG2    = 6,
  parameter int unsigned FWFT          = FWFT_MODE_FALL,
  parameter int unsigned AFULL_THRESH  = (1 << DEPTH_LOG2) - 4,
  parameter int unsigned AEMPTY_THRESH = 4
) (
  input  logic                   iClock,
  input  logic                   iReset,
  scfifo_param_withcount_if.slave bus
);
  localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
  localparam int unsigned CW        = count_width(DEPTH_LOG2);
  localparam logic [CW-1:0] DEPTH_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_CNT = CW'(AEMPTY_THRESH);
  localparam logic          AFULL_RST  = (AFULL_THRESH == 0);

  logic [CW-1:0]         count_q, count_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic                  full_q, full_d;
  logic                  afull_q, afull_d;
  logic                  empty_q, empty_d;
  logic                  aempty_q, aempty_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  pop_ok_c, push_ok_c;
  logic [DATA_WIDTH-1:0] head_c;

  // Accept decisions, next count/pointers, and flags derived from the next count.
  always_comb begin
    pop_ok_c  = bus.iPopEnable & (count_q != '0);
    push_ok_c = bus.iPushEnable & ((count_q != DEPTH_CNT) | pop_ok_c);
    count_d   = count_q + CW'(push_ok_c) - CW'(pop_ok_c);
    wr_ptr_d  = wr_ptr_q + DEPTH_LOG2'(push_ok_c);
    rd_ptr_d  = rd_ptr_q + DEPTH_LOG2'(pop_ok_c);
    full_d    = (count_d == DEPTH_CNT);
    afull_d   = (count_d >= AFULL_CNT);
    empty_d   = (count_d == '0);
    aempty_d  = (count_d <= AEMPTY_CNT);
    // A new error in the same cycle as a clear keeps the flag set.
    ovf_d     = (ovf_q & ~bus.iClearErr) | (bus.iPushEnable & ~push_ok_c);
    unf_d     = (unf_q & ~bus.iClearErr) | (bus.iPopEnable & ~pop_ok_c);
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      afull_q  <= AFULL_RST;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      empty_q  <= empty_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  scfifo_regarray #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_regarray (
    .clk     (iClock),
    .we      (push_ok_c),
    .waddr   (wr_ptr_q),
    .wdata   (bus.iPushData),
    .raddr   (rd_ptr_q),
    .rdata_c (head_c)
  );

  generate
    if (FWFT == FWFT_MODE_FALL) begin : g_fwft
      // Head is forced to zero while empty so unwritten storage never leaks out.
      assign bus.oPopData = empty_q ? '0 : head_c;
    end else begin : g_regread
      logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d;

      always_comb begin
        pop_data_d = pop_data_q;
        if (pop_ok_c) begin
          pop_data_d = head_c;
        end
      end

      always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
          pop_data_q <= '0;
        end else begin
          pop_data_q <= pop_data_d;
        end
      end

      assign bus.oPopData = pop_data_q;
    end
  endgenerate

  assign bus.oDataCount   = count_q;
  assign bus.oIsFull      = full_q;
  assign bus.oAlmostFull  = afull_q;
  assign bus.oIsEmpty     = empty_q;
  assign bus.oAlmostEmpty = aempty_q;
  assign bus.oOverflow    = ovf_q;
  assign bus.oUnderflow   = unf_q;
endmodule

// File: tb/tb_scfifo_param_withcount.sv
// Bench for scfifo_param_withcount: a 64x64 fall-through instance and a 8x32
// registered-read instance, checked every cycle against queue models.
module tb_scfifo_param_withcount;
  import scfifo_pkg::*;

  localparam int DA = 64, LA = 6, DEPA = 64, AF_A = 60, AE_A = 4;
  localparam int DB = 32, LB = 3, DEPB = 8, AF_B = 4, AE_B = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  scfifo_param_withcount_if #(.DATA_WIDTH(DA), .DEPTH_LOG2(LA)) if_a ();
  scfifo_param_withcount_if #(.DATA_WIDTH(DB), .DEPTH_LOG2(LB)) if_b ();

  scfifo_param_withcount #(
    .DATA_WIDTH(DA), .DEPTH_LOG2(LA), .FWFT(1), .AFULL_THRESH(AF_A), .AEMPTY_THRESH(AE_A)
  ) dut_a (.iClock(clk), .iReset(rst_n), .bus(if_a));

  scfifo_param_withcount #(
    .DATA_WIDTH(DB), .DEPTH_LOG2(LB), .FWFT(0), .AFULL_THRESH(AF_B), .AEMPTY_THRESH(AE_B)
  ) dut_b (.iClock(clk), .iReset(rst_n), .bus(if_b));

  // Reference model: plain queues plus sticky flags and the registered read value.
  logic [DA-1:0] qa[$];
  logic [DB-1:0] qb[$];
  logic          ovf_a = 1'b0, unf_a = 1'b0, ovf_b = 1'b0, unf_b = 1'b0;
  logic [DB-1:0] pd_b = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit pop_ok, push_ok;
    pop_ok  = if_a.iPopEnable && qa.size() != 0;
    push_ok = if_a.iPushEnable && (qa.size() != DEPA || pop_ok);
    if (if_a.iClearErr) begin ovf_a = 1'b0; unf_a = 1'b0; end
    if (if_a.iPushEnable && !push_ok) ovf_a = 1'b1;
    if (if_a.iPopEnable && !pop_ok) unf_a = 1'b1;
    if (pop_ok) void'(qa.pop_front());
    if (push_ok) qa.push_back(if_a.iPushData);

    pop_ok  = if_b.iPopEnable && qb.size() != 0;
    push_ok = if_b.iPushEnable && (qb.size() != DEPB || pop_ok);
    if (if_b.iClearErr) begin ovf_b = 1'b0; unf_b = 1'b0; end
    if (if_b.iPushEnable && !push_ok) ovf_b = 1'b1;
    if (if_b.iPopEnable && !pop_ok) unf_b = 1'b1;
    if (pop_ok) pd_b = qb.pop_front();
    if (push_ok) qb.push_back(if_b.iPushData);
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      qa.delete(); qb.delete();
      ovf_a = 1'b0; unf_a = 1'b0; ovf_b = 1'b0; unf_b = 1'b0;
      pd_b = '0;
    end else begin
      model_step();
    end
  end

  task automatic compare_all();
    int n;
    n = qa.size();
    check("a.count",  64'(if_a.oDataCount),   64'(n));
    check("a.empty",  64'(if_a.oIsEmpty),     64'(n == 0));
    check("a.full",   64'(if_a.oIsFull),      64'(n == DEPA));
    check("a.afull",  64'(if_a.oAlmostFull),  64'(n >= AF_A));
    check("a.aempty", 64'(if_a.oAlmostEmpty), 64'(n <= AE_A));
    check("a.ovf",    64'(if_a.oOverflow),    64'(ovf_a));
    check("a.unf",    64'(if_a.oUnderflow),   64'(unf_a));
    if (n != 0) check("a.head", 64'(if_a.oPopData), 64'(qa[0]));
    else        check("a.head", 64'(if_a.oPopData), 64'(0));
    n = qb.size();
    check("b.count",  64'(if_b.oDataCount),   64'(n));
    check("b.empty",  64'(if_b.oIsEmpty),     64'(n == 0));
    check("b.full",   64'(if_b.oIsFull),      64'(n == DEPB));
    check("b.afull",  64'(if_b.oAlmostFull),  64'(n >= AF_B));
    check("b.aempty", 64'(if_b.oAlmostEmpty), 64'(n <= AE_B));
    check("b.ovf",    64'(if_b.oOverflow),    64'(ovf_b));
    check("b.unf",    64'(if_b.oUnderflow),   64'(unf_b));
    check("b.pop_data", 64'(if_b.oPopData),   64'(pd_b));
  endtask

  initial forever begin
    @(negedge clk);
    compare_all();
  end

  task automatic cyc_a(input logic push, input logic [DA-1:0] d, input logic pop, input logic clr);
    if_a.iPushEnable = push; if_a.iPushData = d; if_a.iPopEnable = pop; if_a.iClearErr = clr;
    @(posedge clk); #1;
    if_a.iPushEnable = 1'b0; if_a.iPopEnable = 1'b0; if_a.iClearErr = 1'b0;
  endtask

  task automatic cyc_b(input logic push, input logic [DB-1:0] d, input logic pop, input logic clr);
    if_b.iPushEnable = push; if_b.iPushData = d; if_b.iPopEnable = pop; if_b.iClearErr = clr;
    @(posedge clk); #1;
    if_b.iPushEnable = 1'b0; if_b.iPopEnable = 1'b0; if_b.iClearErr = 1'b0;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, ".count"},  64'(if_a.oDataCount),   64'(0));
    check({tag, ".empty"},  64'(if_a.oIsEmpty),     64'(1));
    check({tag, ".full"},   64'(if_a.oIsFull),      64'(0));
    check({tag, ".afull"},  64'(if_a.oAlmostFull),  64'(0));
    check({tag, ".aempty"}, 64'(if_a.oAlmostEmpty), 64'(1));
    check({tag, ".ovf"},    64'(if_a.oOverflow),    64'(0));
    check({tag, ".unf"},    64'(if_a.oUnderflow),   64'(0));
    check({tag, ".data"},   64'(if_a.oPopData),     64'(0));
  endtask

  initial begin
    if_a.iPushEnable = 1'b0; if_a.iPopEnable = 1'b0; if_a.iClearErr = 1'b0; if_a.iPushData = '0;
    if_b.iPushEnable = 1'b0; if_b.iPopEnable = 1'b0; if_b.iClearErr = 1'b0; if_b.iPushData = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_a("rst_a");
    check("rst_b.data",  64'(if_b.oPopData), 64'(0));
    check("rst_b.empty", 64'(if_b.oIsEmpty), 64'(1));
    rst_n = 1'b1;

    // Fill to full, checking the almost-full threshold crossing.
    for (int i = 0; i < 64; i++) begin
      cyc_a(1'b1, DA'(i), 1'b0, 1'b0);
      if (i == 58) begin
        check("thr.count59", 64'(if_a.oDataCount), 64'(59));
        check("thr.afull59", 64'(if_a.oAlmostFull), 64'(0));
      end
      if (i == 59) check("thr.afull60", 64'(if_a.oAlmostFull), 64'(1));
    end
    check("fill.full",  64'(if_a.oIsFull),    64'(1));
    check("fill.count", 64'(if_a.oDataCount), 64'h40);

    cyc_a(1'b1, DA'(64'hDEAD), 1'b0, 1'b0);
    check("ovf.set",   64'(if_a.oOverflow),  64'(1));
    check("ovf.count", 64'(if_a.oDataCount), 64'h40);
    check("ovf.head",  64'(if_a.oPopData),   64'(0));
    cyc_a(1'b0, '0, 1'b0, 1'b1);
    check("ovf.clr",   64'(if_a.oOverflow),  64'(0));

    // Full with simultaneous push and pop: accepted, count pinned at DEPTH.
    cyc_a(1'b1, DA'(64'h1000), 1'b1, 1'b0);
    check("fullpp.count", 64'(if_a.oDataCount), 64'h40);
    check("fullpp.ovf",   64'(if_a.oOverflow),  64'(0));
    check("fullpp.head",  64'(if_a.oPopData),   64'(1));

    for (int i = 1; i < 64; i++) begin
      check("drain.head", 64'(if_a.oPopData), 64'(i));
      cyc_a(1'b0, '0, 1'b1, 1'b0);
      if (i == 59) check("thr.aempty5", 64'(if_a.oAlmostEmpty), 64'(0));
      if (i == 60) check("thr.aempty4", 64'(if_a.oAlmostEmpty), 64'(1));
    end
    check("drain.new_head", 64'(if_a.oPopData),   64'h1000);
    check("drain.count1",   64'(if_a.oDataCount), 64'(1));
    cyc_a(1'b0, '0, 1'b1, 1'b0);
    check("drain.empty", 64'(if_a.oIsEmpty),   64'(1));
    check("drain.count", 64'(if_a.oDataCount), 64'(0));

    cyc_a(1'b0, '0, 1'b1, 1'b0);
    check("unf.set", 64'(if_a.oUnderflow), 64'(1));
    cyc_a(1'b1, DA'(64'h77), 1'b1, 1'b0);
    check("emptypp.count", 64'(if_a.oDataCount), 64'(1));
    check("emptypp.unf",   64'(if_a.oUnderflow), 64'(1));
    check("emptypp.head",  64'(if_a.oPopData),   64'h77);
    cyc_a(1'b0, '0, 1'b0, 1'b1);
    check("clr.unf", 64'(if_a.oUnderflow), 64'(0));
    check("clr.ovf", 64'(if_a.oOverflow),  64'(0));

    for (int i = 0; i < 63; i++) cyc_a(1'b1, DA'(32'h200 + i), 1'b0, 1'b0);
    cyc_a(1'b1, DA'(64'hBAD), 1'b0, 1'b0);
    check("ovf2.set", 64'(if_a.oOverflow), 64'(1));
    cyc_a(1'b1, DA'(64'hBAD2), 1'b0, 1'b1);
    check("ovf.setwins", 64'(if_a.oOverflow), 64'(1));
    cyc_a(1'b0, '0, 1'b0, 1'b1);
    check("ovf2.clr", 64'(if_a.oOverflow), 64'(0));
    cyc_a(1'b1, DA'(64'hBAD3), 1'b0, 1'b0);
    for (int i = 0; i < 34; i++) cyc_a(1'b0, '0, 1'b1, 1'b0);
    check("mid.count30", 64'(if_a.oDataCount), 64'(30));
    check("mid.ovf",     64'(if_a.oOverflow),  64'(1));

    // Asynchronous reset between clock edges.
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_reset_a("async_rst");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    cyc_a(1'b1, DA'(64'h1), 1'b0, 1'b0);
    check("post_rst.head",  64'(if_a.oPopData),   64'(1));
    check("post_rst.count", 64'(if_a.oDataCount), 64'(1));

    // Registered-read instance.
    cyc_b(1'b1, 32'hA5A5A5A5, 1'b0, 1'b0);
    check("reg.before_pop", 64'(if_b.oPopData),   64'(0));
    check("reg.count1",     64'(if_b.oDataCount), 64'(1));
    cyc_b(1'b0, '0, 1'b1, 1'b0);
    check("reg.after_pop",  64'(if_b.oPopData), 64'hA5A5A5A5);
    check("reg.empty",      64'(if_b.oIsEmpty), 64'(1));
    cyc_b(1'b0, '0, 1'b0, 1'b0);
    cyc_b(1'b0, '0, 1'b0, 1'b0);
    check("reg.held", 64'(if_b.oPopData), 64'hA5A5A5A5);
    cyc_b(1'b0, '0, 1'b1, 1'b0);
    check("reg.unf",          64'(if_b.oUnderflow), 64'(1));
    check("reg.rejected_pop", 64'(if_b.oPopData),   64'hA5A5A5A5);
    cyc_b(1'b0, '0, 1'b0, 1'b1);
    check("reg.clr", 64'(if_b.oUnderflow), 64'(0));
    for (int k = 0; k < 3; k++) cyc_b(1'b1, DB'(32'h100 + k), 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      cyc_b(1'b1, DB'(32'h103 + k), 1'b1, 1'b0);
      check("wrap.data",  64'(if_b.oPopData),   64'(32'h100 + k));
      check("wrap.count", 64'(if_b.oDataCount), 64'(3));
    end

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
